// File: rtl/edge_event_scheduler_pkg.sv
// Shared constants, FSM states and the round-robin index helper for the
// edge event scheduler and its arbiter.
package edge_event_scheduler_pkg;

  localparam int N    = 8;
  localparam int ID_W = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
    return (id == ID_W'(N - 1)) ? '0 : id + ID_W'(1);
  endfunction

endpackage

// File: rtl/edge_event_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of (pending & ~exclude)
// searching from last_id+1 upward with wrap-around.
module rr_pick
  import edge_event_scheduler_pkg::*;
(
  input  logic [N-1:0]    pending_i,
  input  logic [ID_W-1:0] last_id_i,
  input  logic [N-1:0]    exclude_i,
  output logic [ID_W-1:0] winner_o,
  output logic            hit_o
);

  logic [N-1:0]    cand;
  logic [ID_W-1:0] idx;
  logic [ID_W-1:0] winner_c;
  logic            hit_c;

  assign cand = pending_i & ~exclude_i;

  always_comb begin
    hit_c    = 1'b0;
    winner_c = '0;
    idx      = last_id_i;
    for (int k = 0; k < N; k++) begin
      idx = rr_next(idx);
      if (!hit_c && cand[idx]) begin
        hit_c    = 1'b1;
        winner_c = idx;
      end
    end
  end

  assign winner_o = winner_c;
  assign hit_o    = hit_c;

endmodule

// File: rtl/edge_event_scheduler.sv
// Captures per-line change pulses as pending events and serves them one at a
// time over a valid/ready port in round-robin order, flagging lost events.
module edge_event_scheduler
  import edge_event_scheduler_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    evt_in,
  input  logic            en,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  input  logic            out_ready,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overflow,
  input  logic            ovf_clr
);

  state_e          state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    overflow_q, overflow_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic [ID_W-1:0] last_id_q, last_id_d;

  logic            xfer;
  logic [N-1:0]    out_mask;
  logic [N-1:0]    acc_mask;
  logic [ID_W-1:0] pick_base;
  logic [N-1:0]    pick_excl;
  logic [ID_W-1:0] pick_id;
  logic            pick_hit;

  assign xfer     = (state_q == OFFER) && out_ready;
  assign out_mask = N'(1) << out_id_q;
  assign acc_mask = xfer ? out_mask : '0;

  // While offering, the next winner is searched from the line being accepted,
  // skipping it so it only repeats once it is the sole pending line.
  assign pick_base = (state_q == OFFER) ? out_id_q : last_id_q;
  assign pick_excl = (state_q == OFFER) ? out_mask : '0;

  rr_pick u_rr_pick (
    .pending_i (pending_q),
    .last_id_i (pick_base),
    .exclude_i (pick_excl),
    .winner_o  (pick_id),
    .hit_o     (pick_hit)
  );

  always_comb begin
    pending_d  = evt_in | (pending_q & ~acc_mask);
    overflow_d = ovf_clr ? '0 : (overflow_q | (evt_in & pending_q & ~acc_mask));
  end

  always_comb begin
    state_d   = state_q;
    out_id_d  = out_id_q;
    last_id_d = last_id_q;
    case (state_q)
      IDLE: begin
        if (en && pick_hit) begin
          out_id_d = pick_id;
          state_d  = OFFER;
        end
      end
      OFFER: begin
        if (xfer) begin
          last_id_d = out_id_q;
          if (en && pick_hit) begin
            out_id_d = pick_id;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= '0;
      out_id_q   <= '0;
      last_id_q  <= ID_W'(N - 1);
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      out_id_q   <= out_id_d;
      last_id_q  <= last_id_d;
    end
  end

  assign out_valid = (state_q == OFFER);
  assign out_id    = out_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed scenarios against fixed expectations, then random traffic against
// a cycle-level reference model of the scheduling rules.
module tb_edge_event_scheduler;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] evt_in = '0;
  logic       en = 1'b1;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       out_valid;
  logic [2:0] out_id;
  logic [7:0] pending;
  logic [7:0] overflow;

  int checks = 0;
  int errors = 0;

  edge_event_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .evt_in    (evt_in),
    .en        (en),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_ready (out_ready),
    .pending   (pending),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: pending set, sticky overflow, and the current offer.
  logic [7:0] m_pend = '0;
  logic [7:0] m_ovf = '0;
  logic       m_valid = 1'b0;
  int         m_id = 0;
  int         m_last = N - 1;
  logic [7:0] m_np, m_no;
  bit         m_acc, m_a;
  int         m_found, m_idx;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_id = 0; m_last = N - 1;
    end else begin
      m_acc = m_valid && out_ready;
      for (int i = 0; i < N; i++) begin
        m_a     = m_acc && (m_id == i);
        m_np[i] = evt_in[i] || (m_pend[i] && !m_a);
        m_no[i] = !ovf_clr && (m_ovf[i] || (evt_in[i] && m_pend[i] && !m_a));
      end
      m_found = -1;
      if (!m_valid) begin
        if (en) begin
          for (int k = 1; k <= N; k++) begin
            m_idx = (m_last + k) % N;
            if (m_found < 0 && m_pend[m_idx]) m_found = m_idx;
          end
          if (m_found >= 0) begin m_valid = 1'b1; m_id = m_found; end
        end
      end else if (m_acc) begin
        m_last = m_id;
        if (en) begin
          for (int k = 1; k < N; k++) begin
            m_idx = (m_id + k) % N;
            if (m_found < 0 && m_pend[m_idx]) m_found = m_idx;
          end
        end
        if (m_found >= 0) m_id = m_found;
        else m_valid = 1'b0;
      end
      m_pend = m_np;
      m_ovf  = m_no;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; evt_in = '0; out_ready = 1'b0; ovf_clr = 1'b0; en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; evt_in = '0;
    tick(); tick();
    checks++;
    if ({pending, overflow, out_valid, out_id} !== {8'h00, 8'h00, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset got p=%h o=%h v=%b id=%0d want 00 00 0 0", pending, overflow, out_valid, out_id);
    end
    rst_n = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({pending, overflow, out_valid} !== {8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL idle got p=%h o=%h v=%b want 00 00 0", pending, overflow, out_valid);
    end
  endtask

  task automatic test_single();
    en = 1'b1; out_ready = 1'b1; evt_in = 8'h04;
    tick();
    evt_in = '0;
    checks++;
    if ({pending, out_valid} !== {8'h04, 1'b0}) begin
      errors++;
      $display("FAIL single_capture got p=%h v=%b want 04 0", pending, out_valid);
    end
    tick();
    checks++;
    if ({out_valid, out_id} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL single_offer got v=%b id=%0d want 1 2", out_valid, out_id);
    end
    tick();
    checks++;
    if ({pending, out_valid} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL single_done got p=%h v=%b want 00 0", pending, out_valid);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_ids [3];
    exp_ids[0] = 3'd0; exp_ids[1] = 3'd1; exp_ids[2] = 3'd7;
    do_reset();
    out_ready = 1'b1; evt_in = 8'h81;
    tick();
    evt_in = 8'h02;
    tick();
    evt_in = '0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if ({out_valid, out_id} !== {1'b1, exp_ids[n]}) begin
        errors++;
        $display("FAIL fair_seq%0d got v=%b id=%0d want 1 %0d", n, out_valid, out_id, exp_ids[n]);
      end
      tick();
    end
    checks++;
    if ({pending, out_valid} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL fair_end got p=%h v=%b want 00 0", pending, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; evt_in = 8'h10;
    tick();
    evt_in = '0;
    tick();
    for (int n = 0; n < 5; n++) begin
      checks++;
      if ({out_valid, out_id} !== {1'b1, 3'd4}) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b id=%0d want 1 4", n, out_valid, out_id);
      end
      tick();
    end
    evt_in = 8'h10;
    tick();
    evt_in = '0;
    checks++;
    if (overflow !== 8'h10) begin
      errors++;
      $display("FAIL bp_ovf got %h want 10", overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if ({overflow, out_valid, out_id} !== {8'h00, 1'b1, 3'd4}) begin
      errors++;
      $display("FAIL bp_clr got o=%h v=%b id=%0d want 00 1 4", overflow, out_valid, out_id);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({pending, out_valid} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL bp_drain got p=%h v=%b want 00 0", pending, out_valid);
    end
  endtask

  task automatic test_repulse();
    out_ready = 1'b0; evt_in = 8'h08;
    tick();
    evt_in = '0;
    tick();
    checks++;
    if ({out_valid, out_id} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL rp_offer got v=%b id=%0d want 1 3", out_valid, out_id);
    end
    out_ready = 1'b1; evt_in = 8'h08;
    tick();
    evt_in = '0;
    checks++;
    if ({pending, overflow} !== {8'h08, 8'h00}) begin
      errors++;
      $display("FAIL rp_accept got p=%h o=%h want 08 00", pending, overflow);
    end
    tick();
    checks++;
    if ({out_valid, out_id} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL rp_reoffer got v=%b id=%0d want 1 3", out_valid, out_id);
    end
    tick();
    checks++;
    if ({pending, out_valid} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rp_done got p=%h v=%b want 00 0", pending, out_valid);
    end
  endtask

  task automatic test_en_reset();
    out_ready = 1'b0; en = 1'b0; evt_in = 8'h03;
    tick();
    evt_in = '0;
    tick(); tick();
    checks++;
    if ({pending, out_valid} !== {8'h03, 1'b0}) begin
      errors++;
      $display("FAIL en_gate got p=%h v=%b want 03 0", pending, out_valid);
    end
    en = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_id} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL en_offer got v=%b id=%0d want 1 0", out_valid, out_id);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({pending, overflow, out_valid, out_id} !== {8'h00, 8'h00, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL mid_reset got p=%h o=%h v=%b id=%0d want 00 00 0 0", pending, overflow, out_valid, out_id);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      evt_in    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      en        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 24) == 0);
      tick();
      checks++;
      if ({pending, overflow, out_valid} !== {m_pend, m_ovf, m_valid}) begin
        errors++;
        $display("FAIL rand_state cyc=%0d got p=%h o=%h v=%b want p=%h o=%h v=%b",
                 c, pending, overflow, out_valid, m_pend, m_ovf, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (out_id !== 3'(m_id)) begin
          errors++;
          $display("FAIL rand_id cyc=%0d got %0d want %0d", c, out_id, m_id);
        end
      end
    end
    rst_n = 1'b1; evt_in = '0; ovf_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_repulse();
    test_en_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_event_scheduler.md
Name: edge_event_scheduler

Overview:
- Takes the 8 single-cycle per-bit change flags from the input change detector. Holds each flag as a pending event.
- Serves pending events one at a time through a valid/ready output port, using round-robin priority.
- Sits between the change detector and the downstream event consumer, so simultaneous changes on several bits are serialized and none is lost silently.

Parameters:
N, 8, number of event lines.
ID_W, 3, width of event index; equals clog2(N).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
evt_in  in  N  event pulses; any bit high for one cycle is one event on that line.
en  in  1  enables new offers; capture of events continues while low.
out_valid  out  1  an event is being offered.
out_id  out  ID_W  index of the offered event line.
out_ready  in  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high.
pending  out  N  registered per-line pending flags; a line being offered stays set until accepted.
overflow  out  N  sticky flag per line: an event arrived while that line was already pending.
ovf_clr  in  1  clears all overflow bits.

Behaviour:
- Reset: sampled at posedge clk while rst_n=0.
  - pending=0, overflow=0, out_valid=0, out_id=0.
  - Round-robin pointer last_id=N-1, so the first search starts at line 0. FSM goes to IDLE.
  - Reset mid-offer drops the offer and all pending events with no handshake.
- Capture: pending[i] next state = evt_in[i] OR (pending[i] AND NOT acc_i).
  - acc_i = transfer this cycle with out_id==i.
- Overflow: overflow[i] is set when evt_in[i]=1 and pending[i]=1 and NOT acc_i.
  - Accept plus a new pulse on the same line in the same cycle: pending stays 1 and no overflow is flagged.
  - ovf_clr has priority over a same-cycle set, so overflow is cleared; the event itself is still captured.
- Arbitration: a combinational search over the registered pending flags only, never over evt_in.
  - Search order is last_id+1, last_id+2, ... with wrap-around modulo N.
  - The first set bit wins.
- FSM states: IDLE and OFFER.
  - IDLE:
    - If en=1 and any pending bit is set: register out_id=winner, out_valid=1, go to OFFER.
    - Otherwise stay in IDLE.
  - OFFER:
    - out_valid=1. out_id is held stable until a transfer, and is never retracted, even if en drops.
    - On transfer: last_id=out_id, and pending[out_id] clears as per the capture rule.
      - If en=1 and another pending bit exists (excluding the accepted line), load the next winner. The search starts after the accepted id and out_valid stays 1, giving back-to-back throughput of 1 event per cycle.
      - Otherwise: out_valid=0, go to IDLE.
    - The accepted line can win again in the next cycle only when it is the sole pending line, i.e. it was re-pulsed during the accept cycle.
- Latency: a pulse sampled at edge E0 sets pending after E0. With an idle port, out_valid is high after E1 (2 edges).
- en=0: pending and overflow keep updating; no new offers are started.
- All outputs are registered; there is no combinational path from out_ready to out_valid or out_id.

Decomposition:
- Shared package: parameters N and ID_W, a state enum {IDLE, OFFER}, and a function that returns the next index with wrap-around.
- Sub-module rr_pick:
  - Inputs: pending mask, last_id, and an exclude mask.
  - Outputs: winner id and any-hit.
  - Purely combinational; reused by other requester arbiters.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> pending=0x00, overflow=0x00, out_valid=0; with evt_in=0 the outputs stay 0.
- Single event: evt_in=0x04 for 1 cycle, out_ready=1 -> out_valid high 2 edges later with out_id=2; after the transfer, pending=0x00 and out_valid=0.
- Multi-line fairness: evt_in=0x81 then 0x02 one cycle later, out_ready=1 -> out_id sequence 0, 1, 7 back-to-back, each valid exactly one cycle.
- Backpressure: evt_in=0x10, out_ready=0 for 5 cycles -> out_valid=1 and out_id=4 stable throughout; a second pulse on bit 4 sets overflow=0x10; ovf_clr -> overflow=0x00.
- Accept plus re-pulse: the line 3 offer is accepted in the same cycle that evt_in=0x08 -> overflow stays 0x00, pending[3] stays 1, and line 3 is offered again next cycle.
- en gating and mid-offer reset: en=0 with evt_in=0x03 -> pending=0x03 and out_valid=0; en=1 -> out_id=0. Then rst_n=0 during the offer -> all outputs reset on the next edge and the offer is dropped.
